// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial datapath units: FSM state encoding
// and a clamped clog2 used to size digit counters.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Never returns less than 1 so a single-digit unit still has a counter bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice used once per digit cycle.
module digit_serial_adder_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
);

    logic c;

    always_comb begin
        c   = ci;
        sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, with valid/ready handshakes on input and output.
//
//   state | meaning
//   IDLE  | waiting for an operand set; in_ready high (outside reset)
//   RUN   | one digit added per cycle; result shifts in from the MSB end
//   DONE  | s/c_out final, out_valid high until out_ready
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2_min1(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_r;
    logic             carry;
    logic             c_out_r;
    logic             out_valid_r;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_co;
    logic [WIDTH-1:0] s_shift;

    digit_serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
        .x   (a_sr[DIGIT-1:0]),
        .y   (b_sr[DIGIT-1:0]),
        .ci  (carry),
        .sum (dig_sum),
        .co  (dig_co)
    );

    // With a single digit the whole result is produced in one cycle.
    generate
        if (DIGIT == WIDTH) begin : g_one_digit
            assign s_shift = dig_sum;
        end else begin : g_multi_digit
            assign s_shift = {dig_sum, s_r[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            carry       <= 1'b0;
            s_r         <= '0;
            c_out_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{sub}};
                        carry <= c_in ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= dig_co;
                    s_r   <= s_shift;
                    if (cnt == LAST) begin
                        cnt         <= '0;
                        c_out_r     <= dig_co;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign c_out     = c_out_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder in three configurations: 8/2, 4/1, 8/8.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // WIDTH=8, DIGIT=2
    logic       iv8 = 0, ir8, ov8, or8 = 0, cin8 = 0, sub8 = 0, co8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    // WIDTH=4, DIGIT=1
    logic       iv4 = 0, ir4, ov4, or4 = 0, cin4 = 0, sub4 = 0, co4;
    logic [3:0] a4 = 0, b4 = 0, s4;
    // WIDTH=8, DIGIT=8
    logic       ivx = 0, irx, ovx, orx = 0, cinx = 0, subx = 0, cox;
    logic [7:0] ax = 0, bx = 0, sx;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .c_in(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8), .c_out(co8));

    digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .c_in(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .s(s4), .c_out(co4));

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) ux (
        .clk(clk), .rst(rst), .in_valid(ivx), .in_ready(irx), .a(ax), .b(bx),
        .c_in(cinx), .sub(subx), .out_valid(ovx), .out_ready(orx), .s(sx), .c_out(cox));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb, input logic [8:0] exp_cs, input int exp_lat);
        int lat;
        start8(a, b, ci, sb);
        wait8(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_cs"}, {co8, s8}, exp_cs);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    initial begin
        int lat;
        logic [3:0] beff;
        logic [4:0] tot;

        // reset state
        tick();
        chk("rst_in_ready", ir8, 1'b0);
        chk("rst_out", {ov8, co8, s8}, 10'h000);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {ir8, ir4, irx}, 3'b111);

        // 1: add with full carry-out, latency 4
        run8("t1", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 4);

        // 2: subtract, no borrow then borrow
        run8("t2a", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 4);
        run8("t2b", 8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF, 4);

        // 3: backpressure with in_valid asserted in DONE
        start8(8'h12, 8'h34, 1'b0, 1'b0);
        wait8(lat);
        chk("t3_lat", lat, 4);
        a8 = 8'hAA; b8 = 8'h55; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold", {ov8, ir8, co8, s8}, {1'b1, 1'b0, 1'b0, 8'h46});
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("t3_release", {ov8, ir8, co8, s8}, {1'b0, 1'b1, 1'b0, 8'h46});

        // 4: reset after two RUN cycles, then a clean operation
        start8(8'h55, 8'h11, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t4_in_ready_rst", ir8, 1'b0);
        tick();
        chk("t4_abandon", {ov8, co8, s8}, 10'h000);
        rst = 1'b0;
        #1;
        chk("t4_in_ready", ir8, 1'b1);
        run8("t4", 8'h3C, 8'h44, 1'b0, 1'b0, 9'h080, 4);

        // 5: WIDTH=4 DIGIT=1 exhaustive
        for (int v = 0; v < 1024; v++) begin
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sub4 = v[9];
            beff = sub4 ? ~b4 : b4;
            tot  = {1'b0, a4} + {1'b0, beff} + {4'b0, cin4 ^ sub4};
            iv4 = 1'b1;
            tick();
            iv4 = 1'b0;
            lat = 0;
            while (!ov4 && lat < 20) begin
                tick();
                lat++;
            end
            chk("t5_lat", lat, 4);
            chk("t5_cs", {co4, s4}, tot);
            or4 = 1'b1;
            tick();
            or4 = 1'b0;
        end

        // 6: WIDTH=8 DIGIT=8 single digit cycle
        ax = 8'h80; bx = 8'h80; cinx = 1'b1; subx = 1'b0; ivx = 1'b1;
        tick();
        ivx = 1'b0;
        lat = 0;
        while (!ovx && lat < 20) begin
            tick();
            lat++;
        end
        chk("t6_lat", lat, 1);
        chk("t6_cs", {cox, sx}, 9'h101);
        orx = 1'b1;
        tick();
        orx = 1'b0;
        chk("t6_idle", {ovx, irx}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
